// File: rtl/enm_pkg.sv
// rtl/enm_pkg.sv - shared enemy constants, round state type and damage helper
package enm_pkg;

  localparam int NUM_ENM = 4;
  localparam int HP_W    = 7;
  localparam int POS_W   = 10;
  localparam int ID_W    = $clog2(NUM_ENM);
  localparam int IFR_W   = 4;

  // Movement phases switch at 80 and 40 HP, so the start value must stay above 80.
  localparam logic [HP_W-1:0]  HP_INIT_DEF = 7'd100;
  localparam logic [HP_W-1:0]  DMG_DEF     = 7'd10;
  localparam logic [POS_W-1:0] HIT_W_DEF   = 10'd16;
  localparam logic [POS_W-1:0] HIT_H_DEF   = 10'd16;
  localparam logic [IFR_W-1:0] IFRAMES_DEF = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CLEAR = 2'd2
  } enm_state_e;

  function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                   input logic [HP_W-1:0] dmg);
    return (hp > dmg) ? (hp - dmg) : '0;
  endfunction

endpackage

// File: rtl/enm_hp_ctrl_if.sv
// rtl/enm_hp_ctrl_if.sv - bullet, enemy feedback and HP bus of the enemy HP controller
interface enm_hp_ctrl_if;
  import enm_pkg::*;

  logic             start;
  logic             bullet_valid;
  logic [POS_W-1:0] bx;
  logic [POS_W-1:0] by;
  logic [POS_W-1:0] enmx1, enmx2, enmx3, enmx4;
  logic [POS_W-1:0] enmy1, enmy2, enmy3, enmy4;
  logic             enm1, enm2, enm3, enm4;
  logic [HP_W-1:0]  enmhp1, enmhp2, enmhp3, enmhp4;
  logic             bullet_ack;
  logic [ID_W-1:0]  hit_id;
  logic             kill;
  logic             clear;

  modport master (
    output start, bullet_valid, bx, by,
    output enmx1, enmx2, enmx3, enmx4,
    output enmy1, enmy2, enmy3, enmy4,
    output enm1, enm2, enm3, enm4,
    input  enmhp1, enmhp2, enmhp3, enmhp4,
    input  bullet_ack, hit_id, kill, clear
  );

  modport slave (
    input  start, bullet_valid, bx, by,
    input  enmx1, enmx2, enmx3, enmx4,
    input  enmy1, enmy2, enmy3, enmy4,
    input  enm1, enm2, enm3, enm4,
    output enmhp1, enmhp2, enmhp3, enmhp4,
    output bullet_ack, hit_id, kill, clear
  );

endinterface

// File: rtl/enm_hit_box.sv
// rtl/enm_hit_box.sv - combinational bullet-versus-enemy hit box test
module enm_hit_box
  import enm_pkg::*;
(
  input  logic [POS_W-1:0] i_bx,
  input  logic [POS_W-1:0] i_by,
  input  logic [POS_W-1:0] i_ex,
  input  logic [POS_W-1:0] i_ey,
  input  logic [POS_W-1:0] i_hit_w,
  input  logic [POS_W-1:0] i_hit_h,
  output logic             o_in_box
);

  logic [POS_W:0] w_dx;
  logic [POS_W:0] w_dy;
  logic [POS_W:0] w_adx;
  logic [POS_W:0] w_ady;

  // One extra bit keeps the difference exact, so screen edges never wrap into each other.
  assign w_dx  = {1'b0, i_bx} - {1'b0, i_ex};
  assign w_dy  = {1'b0, i_by} - {1'b0, i_ey};
  assign w_adx = w_dx[POS_W] ? (~w_dx + 1'b1) : w_dx;
  assign w_ady = w_dy[POS_W] ? (~w_dy + 1'b1) : w_dy;

  assign o_in_box = (w_adx < {1'b0, i_hit_w}) && (w_ady < {1'b0, i_hit_h});

endmodule

// File: rtl/enm_hp_ctrl.sv
// rtl/enm_hp_ctrl.sv - enemy hit points, bullet hit arbitration and round-clear FSM
module enm_hp_ctrl
  import enm_pkg::*;
#(
  parameter logic [HP_W-1:0]  HP_INIT = HP_INIT_DEF,
  parameter logic [HP_W-1:0]  DMG     = DMG_DEF,
  parameter logic [POS_W-1:0] HIT_W   = HIT_W_DEF,
  parameter logic [POS_W-1:0] HIT_H   = HIT_H_DEF,
  parameter logic [IFR_W-1:0] IFRAMES = IFRAMES_DEF
) (
  input  logic         clk22,
  input  logic         rst_n,
  enm_hp_ctrl_if.slave bus
);

  enm_state_e r_state;
  enm_state_e w_state_nxt;

  logic [HP_W-1:0]  r_hp  [NUM_ENM];
  logic [IFR_W-1:0] r_ifr [NUM_ENM];
  logic             r_ack;
  logic             r_kill;
  logic [ID_W-1:0]  r_hit_id;

  logic [POS_W-1:0] w_ex [NUM_ENM];
  logic [POS_W-1:0] w_ey [NUM_ENM];
  logic [NUM_ENM-1:0] w_alive;
  logic [NUM_ENM-1:0] w_in_box;
  logic [NUM_ENM-1:0] w_cand;
  logic             w_bullet_ok;
  logic             w_all_dead;
  logic             w_hit;
  logic [ID_W-1:0]  w_sel;
  logic [HP_W-1:0]  w_new_hp;

  assign w_ex[0] = bus.enmx1;
  assign w_ex[1] = bus.enmx2;
  assign w_ex[2] = bus.enmx3;
  assign w_ex[3] = bus.enmx4;
  assign w_ey[0] = bus.enmy1;
  assign w_ey[1] = bus.enmy2;
  assign w_ey[2] = bus.enmy3;
  assign w_ey[3] = bus.enmy4;
  assign w_alive = {bus.enm4, bus.enm3, bus.enm2, bus.enm1};

  for (genvar g = 0; g < NUM_ENM; g++) begin : g_box
    enm_hit_box u_box (
      .i_bx     (bus.bx),
      .i_by     (bus.by),
      .i_ex     (w_ex[g]),
      .i_ey     (w_ey[g]),
      .i_hit_w  (HIT_W),
      .i_hit_h  (HIT_H),
      .o_in_box (w_in_box[g])
    );
  end

  // A bullet already acked this tick is still on the bus; it must not be counted again.
  assign w_bullet_ok = (r_state == PLAY) && bus.bullet_valid && !r_ack;

  always_comb begin
    w_cand     = '0;
    w_all_dead = 1'b1;
    for (int n = 0; n < NUM_ENM; n++) begin
      w_cand[n] = w_bullet_ok && w_alive[n] && (r_hp[n] != '0) &&
                  (r_ifr[n] == '0) && w_in_box[n];
      if (r_hp[n] != '0) w_all_dead = 1'b0;
    end
  end

  // Scan downward so the lowest-index candidate is the one left in w_sel.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int n = NUM_ENM - 1; n >= 0; n--) begin
      if (w_cand[n]) begin
        w_hit = 1'b1;
        w_sel = ID_W'(n);
      end
    end
  end

  assign w_new_hp = hp_after_hit(r_hp[w_sel], DMG);

  always_ff @(posedge clk22) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = PLAY;
      PLAY:    if (!bus.start && w_all_dead) w_state_nxt = CLEAR;
      CLEAR:   if (bus.start) w_state_nxt = PLAY;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk22) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_ENM; n++) begin
        r_hp[n]  <= '0;
        r_ifr[n] <= '0;
      end
      r_ack    <= 1'b0;
      r_kill   <= 1'b0;
      r_hit_id <= '0;
    end else if (bus.start) begin
      for (int n = 0; n < NUM_ENM; n++) begin
        r_hp[n]  <= HP_INIT;
        r_ifr[n] <= '0;
      end
      r_ack  <= 1'b0;
      r_kill <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_ENM; n++) begin
        if (r_ifr[n] != '0) r_ifr[n] <= r_ifr[n] - 1'b1;
      end
      r_ack  <= w_hit;
      r_kill <= w_hit && (w_new_hp == '0);
      if (w_hit) begin
        r_hp[w_sel]  <= w_new_hp;
        r_ifr[w_sel] <= IFRAMES;
        r_hit_id     <= w_sel;
      end
    end
  end

  assign bus.enmhp1     = r_hp[0];
  assign bus.enmhp2     = r_hp[1];
  assign bus.enmhp3     = r_hp[2];
  assign bus.enmhp4     = r_hp[3];
  assign bus.bullet_ack = r_ack;
  assign bus.hit_id     = r_hit_id;
  assign bus.kill       = r_kill;
  assign bus.clear      = (r_state == CLEAR);

endmodule

// File: tb/tb_enm_hp_ctrl.sv
// tb/tb_enm_hp_ctrl.sv - scoreboard bench for the enemy HP controller
module tb_enm_hp_ctrl;
  import enm_pkg::*;

  logic clk22 = 1'b0;
  logic rst_n;
  always #5 clk22 = ~clk22;

  enm_hp_ctrl_if bif ();
  enm_hp_ctrl_if sif ();

  enm_hp_ctrl u_dut (
    .clk22 (clk22),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // Second instance whose HP is not a multiple of DMG, to reach the saturating case.
  enm_hp_ctrl #(
    .HP_INIT (7'd87),
    .DMG     (7'd40),
    .IFRAMES (4'd0)
  ) u_sat (
    .clk22 (clk22),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [6:0] hp;
    logic       kill;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [6:0] exp_hp[4];

  function automatic logic [6:0] hp_of(input int n);
    case (n)
      0:       return bif.enmhp1;
      1:       return bif.enmhp2;
      2:       return bif.enmhp3;
      default: return bif.enmhp4;
    endcase
  endfunction

  function automatic void push_exp(input int id, input logic [6:0] hp, input logic kill);
    exp_t e;
    e.id   = 2'(id);
    e.hp   = hp;
    e.kill = kill;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk22);
    #1;
  endtask

  task automatic aim(input int n);
    case (n)
      0:       begin bif.bx = 10'd50;  bif.by = 10'd45;  end
      1:       begin bif.bx = 10'd300; bif.by = 10'd300; end
      2:       begin bif.bx = 10'd310; bif.by = 10'd300; end
      default: begin bif.bx = 10'd600; bif.by = 10'd600; end
    endcase
  endtask

  task automatic check_all_hp(input string name, input logic [6:0] want);
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (hp_of(n) !== want) begin
        n_errors++;
        $display("FAIL %s enmhp%0d: got %0d, want %0d", name, n + 1, hp_of(n), want);
      end
    end
  endtask

  always @(posedge clk22) begin : monitor
    exp_t e;
    #1;
    if (bif.bullet_ack === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_ack: hit_id=%0d, want no ack", bif.hit_id);
      end else begin
        e = sb.pop_front();
        if (bif.hit_id !== e.id || hp_of(int'(e.id)) !== e.hp || bif.kill !== e.kill) begin
          n_errors++;
          $display("FAIL sb_hit: got id=%0d hp=%0d kill=%0b, want id=%0d hp=%0d kill=%0b",
                   bif.hit_id, hp_of(int'(bif.hit_id)), bif.kill, e.id, e.hp, e.kill);
        end
      end
    end else if (bif.kill !== 1'b0) begin
      n_checks++;
      n_errors++;
      $display("FAIL kill_without_ack: kill=%0b, want 0", bif.kill);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bif.start = 1'b0; bif.bullet_valid = 1'b0; bif.bx = '0; bif.by = '0;
    bif.enmx1 = 10'd40;  bif.enmy1 = 10'd40;
    bif.enmx2 = 10'd300; bif.enmy2 = 10'd300;
    bif.enmx3 = 10'd310; bif.enmy3 = 10'd300;
    bif.enmx4 = 10'd600; bif.enmy4 = 10'd600;
    {bif.enm1, bif.enm2, bif.enm3, bif.enm4} = 4'b1111;
    sif.start = 1'b0; sif.bullet_valid = 1'b0; sif.bx = '0; sif.by = '0;
    sif.enmx1 = '0; sif.enmy1 = '0; sif.enmx2 = '0; sif.enmy2 = '0;
    sif.enmx3 = '0; sif.enmy3 = '0; sif.enmx4 = 10'd500; sif.enmy4 = 10'd500;
    {sif.enm1, sif.enm2, sif.enm3, sif.enm4} = 4'b0001;
    tick();
    tick();
    check_all_hp("reset", 7'd0);
    n_checks++;
    if ({bif.bullet_ack, bif.kill, bif.clear, bif.hit_id} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_pulses: ack=%0b kill=%0b clear=%0b hit_id=%0d, want all 0",
               bif.bullet_ack, bif.kill, bif.clear, bif.hit_id);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start();
    aim(0);
    bif.bullet_valid = 1'b1;
    tick();
    bif.bullet_valid = 1'b0;
    n_checks++;
    if (bif.bullet_ack !== 1'b0 || bif.enmhp1 !== 7'd0) begin
      n_errors++;
      $display("FAIL idle_bullet: ack=%0b hp1=%0d, want 0 and 0", bif.bullet_ack, bif.enmhp1);
    end
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    for (int n = 0; n < 4; n++) exp_hp[n] = 7'd100;
    check_all_hp("start", 7'd100);
    repeat (4) tick();
    n_checks++;
    if (bif.clear !== 1'b0) begin
      n_errors++;
      $display("FAIL start_clear: got %0b, want 0", bif.clear);
    end
  endtask

  task automatic test_single_hit();
    bif.bx = 10'd50; bif.by = 10'd45;
    bif.bullet_valid = 1'b1;
    exp_hp[0] = 7'd90;
    push_exp(0, 7'd90, 1'b0);
    #2;
    n_checks++;
    if (bif.enmhp1 !== 7'd100) begin
      n_errors++;
      $display("FAIL hit_early: hp1=%0d before edge, want 100", bif.enmhp1);
    end
    tick();
    n_checks++;
    if (bif.bullet_ack !== 1'b1 || bif.enmhp1 !== 7'd90 || bif.hit_id !== 2'd0) begin
      n_errors++;
      $display("FAIL hit_latency: ack=%0b hp1=%0d id=%0d, want 1, 90, 0",
               bif.bullet_ack, bif.enmhp1, bif.hit_id);
    end
    tick();
    bif.bullet_valid = 1'b0;
    n_checks++;
    if (bif.bullet_ack !== 1'b0 || bif.enmhp1 !== 7'd90) begin
      n_errors++;
      $display("FAIL hit_once: ack=%0b hp1=%0d, want 0 and 90", bif.bullet_ack, bif.enmhp1);
    end
  endtask

  task automatic test_overlap();
    repeat (5) tick();
    bif.bx = 10'd305; bif.by = 10'd300;
    bif.bullet_valid = 1'b1;
    exp_hp[1] = 7'd90;
    push_exp(1, 7'd90, 1'b0);
    tick();
    bif.bullet_valid = 1'b0;
    n_checks++;
    if (bif.hit_id !== 2'd1 || bif.enmhp2 !== 7'd90 || bif.enmhp3 !== 7'd100) begin
      n_errors++;
      $display("FAIL overlap: id=%0d hp2=%0d hp3=%0d, want 1, 90, 100",
               bif.hit_id, bif.enmhp2, bif.enmhp3);
    end
    tick();
  endtask

  task automatic test_iframes();
    repeat (5) tick();
    bif.bx = 10'd50; bif.by = 10'd45;
    bif.bullet_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i % 5 == 0) begin
        exp_hp[0] = exp_hp[0] - 7'd10;
        push_exp(0, exp_hp[0], 1'b0);
      end
      tick();
      n_checks++;
      if (bif.bullet_ack !== ((i % 5) == 0)) begin
        n_errors++;
        $display("FAIL iframe_spacing tick %0d: ack=%0b, want %0b",
                 i, bif.bullet_ack, ((i % 5) == 0));
      end
    end
    bif.bullet_valid = 1'b0;
    tick();
    n_checks++;
    if (bif.enmhp1 !== 7'd60) begin
      n_errors++;
      $display("FAIL iframe_hp: hp1=%0d, want 60", bif.enmhp1);
    end
  endtask

  task automatic test_saturate();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    n_checks++;
    if (sif.enmhp4 !== 7'd87) begin
      n_errors++;
      $display("FAIL sat_start: hp4=%0d, want 87", sif.enmhp4);
    end
    sif.bx = 10'd505; sif.by = 10'd495;
    sif.bullet_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (sif.bullet_ack !== 1'b1 || sif.hit_id !== 2'd3 ||
          sif.enmhp4 !== ((k == 0) ? 7'd47 : (k == 1) ? 7'd7 : 7'd0) || sif.kill !== (k == 2)) begin
        n_errors++;
        $display("FAIL sat_hit %0d: ack=%0b id=%0d hp4=%0d kill=%0b", k,
                 sif.bullet_ack, sif.hit_id, sif.enmhp4, sif.kill);
      end
      tick();
      n_checks++;
      if (sif.bullet_ack !== 1'b0 || sif.kill !== 1'b0) begin
        n_errors++;
        $display("FAIL sat_gap %0d: ack=%0b kill=%0b, want 0 and 0", k, sif.bullet_ack, sif.kill);
      end
    end
    sif.bullet_valid = 1'b0;
    n_checks++;
    if (sif.enmhp4 !== 7'd0) begin
      n_errors++;
      $display("FAIL sat_floor: hp4=%0d, want 0", sif.enmhp4);
    end
  endtask

  task automatic test_kill_clear();
    repeat (5) tick();
    for (int n = 0; n < 4; n++) begin
      while (exp_hp[n] != 7'd0) begin
        aim(n);
        bif.bullet_valid = 1'b1;
        exp_hp[n] = exp_hp[n] - 7'd10;
        push_exp(n, exp_hp[n], exp_hp[n] == 7'd0);
        tick();
        bif.bullet_valid = 1'b0;
        if (n == 3 && exp_hp[3] == 7'd0) begin
          n_checks++;
          if (bif.kill !== 1'b1 || bif.clear !== 1'b0) begin
            n_errors++;
            $display("FAIL final_kill: kill=%0b clear=%0b, want 1 and 0", bif.kill, bif.clear);
          end
          tick();
          n_checks++;
          if (bif.clear !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_entry: clear=%0b, want 1", bif.clear);
          end
        end
        repeat (4) tick();
      end
    end
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    for (int n = 0; n < 4; n++) exp_hp[n] = 7'd100;
    check_all_hp("restart", 7'd100);
    n_checks++;
    if (bif.clear !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_clear: clear=%0b, want 0", bif.clear);
    end
  endtask

  task automatic test_start_vs_hit();
    aim(0);
    bif.bullet_valid = 1'b1;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    bif.bullet_valid = 1'b0;
    n_checks++;
    if (bif.bullet_ack !== 1'b0 || bif.enmhp1 !== 7'd100) begin
      n_errors++;
      $display("FAIL start_priority: ack=%0b hp1=%0d, want 0 and 100", bif.bullet_ack, bif.enmhp1);
    end
    tick();
    bif.bullet_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bif.bullet_valid = 1'b0;
    check_all_hp("reset_mid_hit", 7'd0);
    n_checks++;
    if (bif.bullet_ack !== 1'b0 || bif.kill !== 1'b0 || bif.clear !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_hit_pulses: ack=%0b kill=%0b clear=%0b, want 0",
               bif.bullet_ack, bif.kill, bif.clear);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_start();
    test_single_hit();
    test_overlap();
    test_iframes();
    test_saturate();
    test_kill_clear();
    test_start_vs_hit();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d expected hits never acked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
